mem_port_sequencer: RTL and testbench

- Shares the single-ported unified memory between two requesters: instruction fetch, and data accesses (lw/sw plus the memory-indirect jm/bmn/jmor reads decoded by control).
- Arbitrates between the two and sequences a req/ack memory handshake.
- Returns read data with one-cycle done pulses.
- Bounds every access with a timeout that raises a sticky bus error.

---
 rtl/mem_port_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
// Memory port sequencer: arbitrates instruction fetch and data accesses onto a
// single-ported unified memory using a req/ack handshake, returns read data with
// one-cycle done pulses and aborts any access that waits too long (sticky bus_err).
// Optional build macro MEM_SEQ_PERF_CNT_EN adds grant and wait-cycle counters.
module mem_port_sequencer #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned WAIT_MAX       = 16,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err,
  output logic          busy
`ifdef MEM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]   perf_if_grants,
  output logic [31:0]   perf_d_grants,
  output logic [31:0]   perf_wait_cycles
`endif
);

  localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
  localparam int unsigned BCW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [WCW-1:0] WaitLast = WCW'(WAIT_MAX - 1);
  localparam logic [BCW-1:0] BurstMax = BCW'(DATA_BURST_MAX);

  typedef enum logic [1:0] {StIdle, StIfWait, StDWait, StErr} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            bus_err_q, bus_err_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0]  burst_cnt_q, burst_cnt_d;

  logic if_elig, d_elig, grant_if, grant_d;

  // Arbitration: a requester being released this cycle (done high) is not eligible.
  always_comb begin
    if_elig  = if_req & ~if_done_q;
    d_elig   = d_req & ~d_done_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == StIdle) begin
      if (d_elig && !((burst_cnt_q == BurstMax) && if_elig)) begin
        grant_d = 1'b1;
      end else if (if_elig) begin
        grant_if = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = bus_err_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        wait_cnt_d = '0;
        if (grant_d) begin
          state_d     = StDWait;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Only consecutive data grants that hold off a waiting fetch count.
          if (if_req) begin
            if (burst_cnt_q != BurstMax) burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            burst_cnt_d = '0;
          end
        end else if (grant_if) begin
          state_d     = StIfWait;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          burst_cnt_d = '0;
        end
      end
      StIfWait, StDWait: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          if (state_q == StIfWait) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          // Last permitted wait cycle without ack: abort, no done pulse.
          if (wait_cnt_q == WaitLast) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = StErr;
          end
        end
      end
      StErr: begin
        mem_req_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign busy      = (state_q != StIdle);

`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_d_q, perf_wait_q;

  // Wrapping grant and stalled-request counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_q   <= '0;
      perf_d_q    <= '0;
      perf_wait_q <= '0;
    end else begin
      if (grant_if) perf_if_q <= perf_if_q + 32'd1;
      if (grant_d) perf_d_q <= perf_d_q + 32'd1;
      if (mem_req_q && !mem_ack) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_if_grants   = perf_if_q;
  assign perf_d_grants    = perf_d_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench for mem_port_sequencer: directed scenarios plus a random
// phase, checked every cycle against a transaction-level reference model.
module tb_mem_port_sequencer;
  localparam int unsigned AW             = 32;
  localparam int unsigned DW             = 32;
  localparam int unsigned WAIT_MAX       = 16;
  localparam int unsigned DATA_BURST_MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_done, d_req, d_we, d_done;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, bus_err, busy;
`ifdef MEM_SEQ_PERF_CNT_EN
  logic [31:0]   perf_if_grants, perf_d_grants, perf_wait_cycles;
`endif

  always #5 clk = ~clk;

  mem_port_sequencer #(
    .AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX), .DATA_BURST_MAX(DATA_BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .busy(busy)
`ifdef MEM_SEQ_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one outstanding access, memory contents, expected done pulses.
  bit          act, act_d, e_we, err;
  logic [31:0] e_addr, e_wdata;
  int          waited, delay, dly_mode, burst;
  bit          exp_ifd, exp_dd;
  logic [31:0] exp_ifr, exp_dr;
  logic [31:0] mem_model [logic [31:0]];

  // Requester behaviour and staged directed requests.
  bit          rnd, d_rep, st_if, st_d, st_d_we;
  int          if_rep;
  logic [31:0] st_if_addr, st_d_addr, st_d_wdata;

  // Observations taken from the DUT.
  bit          prev_mreq;
  logic [31:0] grant_log [$];
  int          cyc, ifd_seen, dd_seen, mreq_seen, ifd_cyc, dd_cyc;
  logic [31:0] obs_ifr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'h5A3C};
  endfunction

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = 32'($urandom_range(0, 15)) << 2;
  endtask

  task automatic new_data(input bit may_store);
    d_req   = 1'b1;
    d_we    = may_store ? 1'($urandom_range(0, 1)) : 1'b0;
    d_addr  = 32'h100 + (32'($urandom_range(0, 15)) << 2);
    d_wdata = $urandom;
  endtask

  // One clock cycle: observe at the falling edge, then drive inputs for the next edge.
  task automatic tick();
    bit ifd_now, dd_now, ei, ed;
    @(negedge clk);
    cyc++;
    check("if_done", if_done, exp_ifd);
    check("if_rdata", if_rdata, exp_ifr);
    check("d_done", d_done, exp_dd);
    check("d_rdata", d_rdata, exp_dr);
    check("bus_err", bus_err, err);
    check("busy", busy, act || err);
    check("mem_req", mem_req, act);
    if (act) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_we", mem_we, e_we);
      if (act_d) check("mem_wdata", mem_wdata, e_wdata);
    end
    if (mem_req && !prev_mreq) grant_log.push_back(mem_addr);
    prev_mreq = mem_req;
    if (if_done) begin ifd_seen++; ifd_cyc = cyc; obs_ifr = if_rdata; end
    if (d_done) begin dd_seen++; dd_cyc = cyc; end
    if (mem_req) mreq_seen++;
    ifd_now = exp_ifd;
    dd_now  = exp_dd;
    exp_ifd = 1'b0;
    exp_dd  = 1'b0;

    // Requesters release on done and may re-request at once.
    if (ifd_now) begin
      if_req = 1'b0;
      if (if_rep > 0) begin
        if_rep--;
        if_req  = 1'b1;
        if_addr = if_addr + 32'd4;
      end else if (rnd && $urandom_range(0, 1) == 1) begin
        new_fetch();
      end
    end else if (rnd && !if_req && $urandom_range(0, 2) == 0) begin
      new_fetch();
    end
    if (dd_now) begin
      d_req = 1'b0;
      if (d_rep) new_data(1'b0);
      else if (rnd && $urandom_range(0, 1) == 1) new_data(1'b1);
    end else if (rnd && !d_req && $urandom_range(0, 2) == 0) begin
      new_data(1'b1);
    end
    if (st_if) begin
      st_if = 1'b0; if_req = 1'b1; if_addr = st_if_addr;
    end
    if (st_d) begin
      st_d = 1'b0; d_req = 1'b1; d_we = st_d_we; d_addr = st_d_addr; d_wdata = st_d_wdata;
    end

    // Memory responder and arbitration prediction.
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (err) begin
      mem_ack = 1'($urandom_range(0, 1));
    end else if (act) begin
      if (waited == delay) begin
        mem_ack = 1'b1;
        if (act_d && e_we) begin
          mem_model[e_addr] = e_wdata;
        end else begin
          mem_rdata = mem_rd(e_addr);
          if (act_d) exp_dr = mem_rdata;
          else exp_ifr = mem_rdata;
        end
        if (act_d) exp_dd = 1'b1;
        else exp_ifd = 1'b1;
        act = 1'b0;
      end else begin
        waited++;
        if (waited == WAIT_MAX) begin
          err = 1'b1;
          act = 1'b0;
        end
      end
    end else begin
      if (rnd) mem_ack = ($urandom_range(0, 3) == 0);
      ei = if_req && !ifd_now;
      ed = d_req && !dd_now;
      if (ed && !(burst == DATA_BURST_MAX && ei)) begin
        act = 1'b1; act_d = 1'b1;
        e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
        burst = if_req ? ((burst < DATA_BURST_MAX) ? burst + 1 : burst) : 0;
      end else if (ei) begin
        act = 1'b1; act_d = 1'b0;
        e_addr = if_addr; e_we = 1'b0;
        burst = 0;
      end
      if (act) begin
        waited = 0;
        delay  = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_if_done", if_done, 0);
    check("rst_d_done", d_done, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_busy", busy, 0);
`ifdef MEM_SEQ_PERF_CNT_EN
    check("rst_perf_if", perf_if_grants, 0);
    check("rst_perf_d", perf_d_grants, 0);
    check("rst_perf_wait", perf_wait_cycles, 0);
`endif
    reset = 1'b0;
    act = 1'b0; err = 1'b0; burst = 0; exp_ifd = 1'b0; exp_dd = 1'b0;
    exp_ifr = '0; exp_dr = '0; prev_mreq = 1'b0;
    if_rep = 0; d_rep = 1'b0; st_if = 1'b0; st_d = 1'b0;
  endtask

  task automatic run_until_idle(input int bound, input string tag);
    int k = 0;
    while ((if_req || d_req || act || st_if || st_d) && k < bound) begin
      tick();
      k++;
    end
    check({"drain_", tag}, 32'(k >= bound), 0);
  endtask

  initial begin
    int base, dbase, ibase, nd;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    rnd = 1'b0; dly_mode = -1; cyc = 0; ifd_seen = 0; dd_seen = 0; mreq_seen = 0;
    ifd_cyc = 0; dd_cyc = 0; obs_ifr = '0; waited = 0; delay = 0;
    do_reset(3);

    // Single fetch, ack two cycles after mem_req rises.
    mem_model[32'h40] = 32'h8C220004;
    grant_log.delete();
    dly_mode = 2; st_if = 1'b1; st_if_addr = 32'h40;
    tick();
    base = cyc;
    run_until_idle(40, "t1");
    check("t1_latency", 32'(ifd_cyc - base), 4);
    check("t1_rdata", obs_ifr, 32'h8C220004);
    check("t1_addr", grant_log[0], 32'h40);

    // Concurrent requests: the store goes first.
    grant_log.delete();
    dly_mode = 0;
    st_if = 1'b1; st_if_addr = 32'h44;
    st_d = 1'b1; st_d_we = 1'b1; st_d_addr = 32'h100; st_d_wdata = 32'hDEADBEEF;
    run_until_idle(40, "t2");
    check("t2_grants", grant_log.size(), 2);
    check("t2_first", grant_log[0], 32'h100);
    check("t2_second", grant_log[1], 32'h44);
    check("t2_order", 32'(dd_cyc < ifd_cyc), 1);

    // Fetch held against continuously re-asserted data: fetch must not starve.
    grant_log.delete();
    dly_mode = -1;
    st_if = 1'b1; st_if_addr = 32'h80; if_rep = 1;
    st_d = 1'b1; st_d_we = 1'b0; st_d_addr = 32'h104; st_d_wdata = 32'h0; d_rep = 1'b1;
    ibase = ifd_seen;
    for (int k = 0; k < 200 && ifd_seen < ibase + 2; k++) tick();
    d_rep = 1'b0;
    run_until_idle(60, "t3");
    check("t3_fetch_dones", 32'(ifd_seen - ibase), 2);
    nd = 0;
    while (nd < grant_log.size() && grant_log[nd] >= 32'h100) nd++;
    check("t3_burst_bound", 32'(nd >= 1 && nd <= int'(DATA_BURST_MAX)), 1);

    // Random traffic with random ack delays and stray acks while idle.
    ibase = ifd_seen; dbase = dd_seen;
    rnd = 1'b1;
    repeat (3000) tick();
    rnd = 1'b0;
    run_until_idle(200, "rnd");
    check("rnd_activity", 32'((ifd_seen - ibase) > 50 && (dd_seen - dbase) > 50), 1);

    // Timeout: ack never returned.
    dly_mode = 1000;
    st_d = 1'b1; st_d_we = 1'b0; st_d_addr = 32'h108; st_d_wdata = 32'h0;
    base = mreq_seen; dbase = dd_seen;
    repeat (25) tick();
    check("t4_mreq_cycles", 32'(mreq_seen - base), 16);
    check("t4_no_d_done", 32'(dd_seen - dbase), 0);
    check("t4_bus_err", bus_err, 1);
    st_if = 1'b1; st_if_addr = 32'h40;
    base = mreq_seen; ibase = ifd_seen;
    repeat (10) tick();
    check("t4_no_grant", 32'(mreq_seen - base), 0);
    check("t4_no_if_done", 32'(ifd_seen - ibase), 0);
    check("t4_err_sticky", bus_err, 1);
    check("t4_busy", busy, 1);

    // Reset in the cycle the data ack arrives.
    do_reset(1);
    dly_mode = 1;
    st_d = 1'b1; st_d_we = 1'b0; st_d_addr = 32'h10C; st_d_wdata = 32'h0;
    tick();
    tick();
    tick();
    check("t5_ack_driven", 32'(mem_ack), 1);
    do_reset(1);
    dly_mode = 0; ibase = ifd_seen; dbase = dd_seen;
    st_if = 1'b1; st_if_addr = 32'h40;
    run_until_idle(40, "t5");
    check("t5_fetch_done", 32'(ifd_seen - ibase), 1);
    check("t5_rdata", obs_ifr, 32'h8C220004);
    check("t5_no_d_done", 32'(dd_seen - dbase), 0);

`ifdef MEM_SEQ_PERF_CNT_EN
    // Three fetches and two loads, each acked one cycle late.
    do_reset(2);
    dly_mode = 1;
    for (int i = 0; i < 3; i++) begin
      st_if = 1'b1; st_if_addr = 32'(i) << 2;
      run_until_idle(40, "perf_if");
    end
    for (int i = 0; i < 2; i++) begin
      st_d = 1'b1; st_d_we = 1'b0; st_d_addr = 32'h100 + (32'(i) << 2); st_d_wdata = 32'h0;
      run_until_idle(40, "perf_d");
    end
    check("perf_if_grants", perf_if_grants, 3);
    check("perf_d_grants", perf_d_grants, 2);
    check("perf_wait_cycles", perf_wait_cycles, 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
